pam_sample_fifo: RTL
====================

# pam_sample_fifo

Synchronous first-word-fall-through byte FIFO between the host sample source (USB/FT245 byte receiver) and the PAM modulator. Absorbs bursty host writes and presents the head sample continuously on `rd_data` while `empty` is low, so the modulator can latch a byte in the same cycle it pulses `rd`. Reports occupancy, almost-full backpressure and sticky overflow/underflow error flags.

## Interface
- `DATA_WIDTH`, 8, sample width in bits
- `DEPTH`, 16, number of entries; power of two, ≥ 4
- `AF_LEVEL`, 12, `almost_full` asserts when `level` ≥ this; 1 ≤ AF_LEVEL ≤ DEPTH

- `clk`  in  1  system clock (120 MHz domain shared with the modulator)
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write strobe from the host side
- `wr_data`  in  DATA_WIDTH  byte to write
- `full`  out  1  `level == DEPTH`
- `almost_full`  out  1  `level >= AF_LEVEL`
- `rd`  in  1  pop strobe from the modulator
- `rd_data`  out  DATA_WIDTH  head entry; valid only while `empty == 0`
- `empty`  out  1  `level == 0`
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `clear_err`  in  1  clears `overflow`/`underflow`
- `overflow`  out  1  sticky: a write was dropped because FIFO was full
- `underflow`  out  1  sticky: `rd` pulsed while empty

## Operation
- Storage: DEPTH×DATA_WIDTH register array; write pointer and read pointer, each $clog2(DEPTH)+1 bits (extra wrap bit). `level = wr_ptr - rd_ptr` modulo 2^(ptr width); `full`/`empty` derived from pointer equality with/without wrap-bit difference.
- Write accepted when `wr_en && (!full || rd_accepted)`: entry stored at `wr_ptr[low bits]`, `wr_ptr` increments, wraps naturally.
- Read accepted when `rd && !empty`: `rd_ptr` increments. `rd_data` is combinationally `mem[rd_ptr[low bits]]`.
- Write while full and no accepted read: data dropped, pointers unchanged, `overflow` set.
- `rd` while empty: no pointer change, `underflow` set. A simultaneous write into an empty FIFO is accepted; the read is not (no pass-through).
- Full with simultaneous read and write: both accepted, `level` stays DEPTH, `full` stays high.
- `clear_err` clears both sticky flags; if a new error occurs in the same cycle, the flag is set (set wins).
- Reset values: pointers 0, `empty`=1, `full`=0, `almost_full`=0, `level`=0, `overflow`=0, `underflow`=0; memory not cleared, `rd_data` undefined. Reset mid-operation discards all contents immediately.

## Timing
- All state updates on posedge `clk`; all status outputs are functions of registered pointers (no input-to-output combinational path except none; `rd_data` depends only on registers).
- Write-to-read latency: 1 cycle. Write accepted at edge N → `empty` low and `rd_data` valid after edge N.
- Pop: `rd` high at edge N → next entry on `rd_data` after edge N; modulator may hold `rd` for consecutive cycles to pop back-to-back.
- `level`, `full`, `almost_full` update after the same edge as the accepted operation.
- Sticky flags set after the edge of the offending cycle.
- Throughput: one write and one read per cycle.

## Configuration
- `PAM_SAMPLE_FIFO_PEAK_EN` defined: adds output `peak_level` ($clog2(DEPTH)+1 bits), the maximum `level` reached since reset or since the last `clear_err` (cleared to current `level` on `clear_err`); reset value 0; updates one cycle after `level`.
- Undefined: no `peak_level` port, no peak register; all other behaviour identical.

## Test plan
- Reset, then write 0x11,0x22,0x33 on consecutive cycles → `empty` low one cycle after first write, `rd_data`=0x11, `level`=3; pop three times → 0x22, 0x33, then `empty`=1, `level`=0.
- Write 16 bytes 0x00..0x0F (DEPTH=16) → `almost_full` high after 12th write, `full` after 16th; write 0xAA → `overflow`=1, `level`=16; pop all → 0x00..0x0F in order, 0xAA never appears.
- Full FIFO, simultaneous `wr_en` (0x55) and `rd` for one cycle → `level` stays 16, `full` stays 1, 0x55 emerges as 16th pop.
- Empty FIFO, `rd` and `wr_en` (0x77) same cycle → `underflow`=1, `level`=1, `rd_data`=0x77 next cycle; `clear_err` → both flags 0.
- Pointer wrap: 40 interleaved write/pop pairs with incrementing data → data order preserved, `level` never exceeds 1, no error flags.
- Assert `rst` with `level`=9 → after one edge `empty`=1, `level`=0, flags 0; with `PAM_SAMPLE_FIFO_PEAK_EN`, `peak_level`=9 before reset and 0 after.

Source files
------------

// File: rtl/pam_sample_fifo.sv
// pam_sample_fifo
//   First-word-fall-through sample FIFO between the host byte receiver and the
//   PAM modulator. The head entry is always presented on rd_data_o while
//   empty_o is low, so the modulator can take the byte in the same cycle it
//   pulses rd_i. Also reports occupancy, almost-full backpressure and sticky
//   overflow/underflow flags.
//
//   Optional build macro: PAM_SAMPLE_FIFO_PEAK_EN adds peak_level_o, which is
//   the highest occupancy seen since reset or since the last clear_err_i.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   wr_en_i         host write strobe
//   wr_data_i       byte to write
//   full_o          level_o == DEPTH
//   almost_full_o   level_o >= AF_LEVEL
//   rd_i            modulator pop strobe
//   rd_data_o       head entry, valid only while empty_o == 0
//   empty_o         level_o == 0
//   level_o         occupancy, 0..DEPTH
//   clear_err_i     clears the sticky error flags
//   overflow_o      sticky: a write was dropped because the FIFO was full
//   underflow_o     sticky: rd_i pulsed while the FIFO was empty
//   peak_level_o    (PAM_SAMPLE_FIFO_PEAK_EN only) peak occupancy
module pam_sample_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    full_o,
    output logic                    almost_full_o,
    input  logic                    rd_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o,
    input  logic                    clear_err_i,
    output logic                    overflow_o,
    output logic                    underflow_o
`ifdef PAM_SAMPLE_FIFO_PEAK_EN
    ,
    output logic [$clog2(DEPTH):0]  peak_level_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_ok, wr_ok;

    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign empty_o       = (wr_ptr_q == rd_ptr_q);
    assign full_o        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign almost_full_o = (level_o >= AF_LVL);
    assign rd_data_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

    always_comb begin
        rd_ok    = rd_i && !empty_o;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        wr_ok    = wr_en_i && (!full_o || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // A new error in the clearing cycle keeps the flag set.
        overflow_d  = (overflow_q  && !clear_err_i) || (wr_en_i && !wr_ok);
        underflow_d = (underflow_q && !clear_err_i) || (rd_i && empty_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

`ifdef PAM_SAMPLE_FIFO_PEAK_EN
    logic [PW-1:0] peak_q, peak_d;

    // Tracks the registered level, so the peak trails level_o by one cycle.
    always_comb begin
        peak_d = peak_q;
        if (clear_err_i) begin
            peak_d = level_o;
        end else if (level_o > peak_q) begin
            peak_d = level_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level_o = peak_q;
`endif

endmodule
